// File: rtl/pim_alu_pkg.sv
// Shared opcode and FSM definitions for the PIM compute blocks.
// Also holds the dispatch rule that picks the first state after a request is accepted.
package pim_alu_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_ADD     = 3'd1,
        OP_SUB     = 3'd2,
        OP_MUL     = 3'd3,
        OP_AND     = 3'd4,
        OP_OR      = 3'd5,
        OP_XOR     = 3'd6,
        OP_ILLEGAL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDSUB,
        ST_MUL,
        ST_FIN
    } alu_state_e;

    // Arithmetic ops need serial compute cycles; everything else finishes immediately.
    function automatic alu_state_e dispatch_state(input alu_op_e o);
        case (o)
            OP_ADD, OP_SUB: dispatch_state = ST_ADDSUB;
            OP_MUL:         dispatch_state = ST_MUL;
            default:        dispatch_state = ST_FIN;
        endcase
    endfunction

    function automatic logic op_is_err(input alu_op_e o);
        op_is_err = (o == OP_NOP) || (o == OP_ILLEGAL);
    endfunction

endpackage

// File: rtl/pim_shift_add_mul.sv
// Unsigned N x N shift-add multiplier. It handles one multiplier bit per cycle and takes N cycles in total.
// The first partial product is folded into the load, so the product is complete after N edges.
module pim_shift_add_mul
    import pim_alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] product,
    output logic           done
);

    localparam int CNT_W = $clog2(N + 1);

    logic [2*N-1:0] acc_q;
    logic [2*N-1:0] mcand_q;
    logic [N-1:0]   mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic           running_q;

    // running_q drops the cycle after done so a stale done never leaks into a later request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            acc_q     <= b[0] ? {{N{1'b0}}, a} : '0;
            mcand_q   <= {{(N-1){1'b0}}, a, 1'b0};
            mplier_q  <= b >> 1;
            cnt_q     <= CNT_W'(1);
            running_q <= 1'b1;
        end else if (running_q && (cnt_q != CNT_W'(N))) begin
            if (mplier_q[0])
                acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end else if (running_q) begin
            running_q <= 1'b0;
        end
    end

    assign product = acc_q;
    assign done    = running_q && (cnt_q == CNT_W'(N));

endmodule

// File: rtl/pim_serial_alu.sv
// Serial PIM ALU. ADD and SUB use a bit-serial adder with the LSB first. MUL uses a shift-add on the low halves.
// The logic ops, NOP and the illegal opcode all complete straight into FIN.
module pim_serial_alu
    import pim_alu_pkg::*;
#(
    parameter int W    = 16,
    parameter int ID_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [ID_W-1:0] id,
    output logic            busy,
    output logic            done,
    output logic [W-1:0]    result,
    output logic [ID_W-1:0] result_id,
    output logic            flag,
    output logic            err
);

    localparam int N     = W / 2;
    localparam int CNT_W = $clog2(W);

    alu_state_e state_q, state_d;
    alu_op_e    op_in, op_q;

    logic            accept;
    logic            mul_start;
    logic            mul_done;
    logic [W-1:0]    mul_product;
    logic [W-1:0]    a_q, b_q, sum_q, sum_next;
    logic [W-1:0]    logic_result;
    logic [ID_W-1:0] id_q;
    logic [CNT_W-1:0] cnt_q;
    logic            carry_q, carry_next, bit_b, bit_s;
    logic            addsub_last;

    assign op_in     = alu_op_e'(op);
    assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_FIN));
    assign mul_start = accept && (op_in == OP_MUL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // FIN behaves like IDLE for acceptance, which gives back-to-back requests with no bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_FIN: state_d = accept ? dispatch_state(op_in) : ST_IDLE;
            ST_ADDSUB:       if (addsub_last) state_d = ST_FIN;
            ST_MUL:          if (mul_done) state_d = ST_FIN;
            default:         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_ADDSUB, ST_MUL: busy = 1'b1;
            ST_FIN:            done = 1'b1;
            default:           ;
        endcase
    end

    // SUB is computed as a + ~b + 1, so the serial carry starts at 1 and b is inverted bit by bit.
    assign bit_b       = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
    assign bit_s       = a_q[0] ^ bit_b ^ carry_q;
    assign carry_next  = (a_q[0] & bit_b) | (a_q[0] & carry_q) | (bit_b & carry_q);
    assign sum_next    = {bit_s, sum_q[W-1:1]};
    assign addsub_last = (state_q == ST_ADDSUB) && (cnt_q == CNT_W'(W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            id_q    <= '0;
            op_q    <= OP_NOP;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            sum_q   <= '0;
            id_q    <= id;
            op_q    <= op_in;
            carry_q <= (op_in == OP_SUB);
            cnt_q   <= '0;
        end else if (state_q == ST_ADDSUB) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            sum_q   <= sum_next;
            carry_q <= carry_next;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        case (op_in)
            OP_AND:  logic_result = a & b;
            OP_OR:   logic_result = a | b;
            OP_XOR:  logic_result = a ^ b;
            default: logic_result = '0;
        endcase
    end

    // Visible results change only on the edge that enters FIN and are held until the next such edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result    <= '0;
            result_id <= '0;
            flag      <= 1'b0;
            err       <= 1'b0;
        end else if (accept && (dispatch_state(op_in) == ST_FIN)) begin
            result    <= logic_result;
            result_id <= id;
            flag      <= 1'b0;
            err       <= op_is_err(op_in);
        end else if (addsub_last) begin
            result    <= sum_next;
            result_id <= id_q;
            flag      <= (op_q == OP_SUB) ? ~carry_next : carry_next;
            err       <= 1'b0;
        end else if ((state_q == ST_MUL) && mul_done) begin
            result    <= mul_product;
            result_id <= id_q;
            flag      <= 1'b0;
            err       <= 1'b0;
        end
    end

    pim_shift_add_mul #(
        .N(N)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a[N-1:0]),
        .b       (b[N-1:0]),
        .product (mul_product),
        .done    (mul_done)
    );

endmodule

// File: tb/tb_pim_serial_alu.sv
// Self-checking bench for pim_serial_alu: directed vectors, back-to-back, reset abort, randomized
// requests against an arithmetic reference model.
module tb_pim_serial_alu;

    localparam int W      = 16;
    localparam int ID_W   = 5;
    localparam int H      = W / 2;
    localparam int BUDGET = 3 * W;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      op = '0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic [ID_W-1:0] id = '0;
    logic            busy, done, flag, err;
    logic [W-1:0]    result;
    logic [ID_W-1:0] result_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pim_serial_alu #(.W(W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .id(id),
        .busy(busy), .done(done), .result(result), .result_id(result_id),
        .flag(flag), .err(err)
    );

    // Reference model: returns {err, flag, result} from plain arithmetic.
    function automatic logic [W+1:0] model(input logic [2:0] m_op, input logic [W-1:0] m_a,
                                           input logic [W-1:0] m_b);
        logic [W:0]   wide;
        logic [W-1:0] pa, pb, r;
        pa = {{H{1'b0}}, m_a[H-1:0]};
        pb = {{H{1'b0}}, m_b[H-1:0]};
        case (m_op)
            3'd1: begin wide = {1'b0, m_a} + {1'b0, m_b}; model = {1'b0, wide[W], wide[W-1:0]}; end
            3'd2: begin r = m_a - m_b; model = {1'b0, (m_a < m_b), r}; end
            3'd3: begin r = pa * pb; model = {2'b00, r}; end
            3'd4: model = {2'b00, m_a & m_b};
            3'd5: model = {2'b00, m_a | m_b};
            3'd6: model = {2'b00, m_a ^ m_b};
            default: model = {1'b1, 1'b0, {W{1'b0}}};
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] m_op);
        case (m_op)
            3'd1, 3'd2: model_latency = W + 1;
            3'd3:       model_latency = H + 1;
            default:    model_latency = 1;
        endcase
    endfunction

    // Issues one request, scrambles inputs after acceptance, and returns at #1 after the done edge.
    task automatic run_req(input logic [2:0] r_op, input logic [W-1:0] r_a, input logic [W-1:0] r_b,
                           input logic [ID_W-1:0] r_id, output int lat, output logic seen,
                           output logic busy_seen);
        @(negedge clk);
        start = 1'b1; op = r_op; a = r_a; b = r_b; id = r_id;
        @(posedge clk); #1;
        busy_seen = busy;
        start = 1'b0;
        op = 3'($urandom); a = W'($urandom); b = W'($urandom); id = ID_W'($urandom);
        lat = 1;
        seen = done;
        while (!seen && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
            seen = done;
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== '0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
        checks++; if (result_id !== '0) begin errors++; $display("[TB] FAIL reset_id: got %h expected 0", result_id); end
        checks++; if (flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_flag: got %b expected 0", flag); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    endtask

    task automatic test_directed;
        int   lat;
        logic seen, bz;
        run_req(3'd1, 16'hFFFF, 16'h0001, 5'd3, lat, seen, bz);
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL add_done_seen: got %b expected 1", seen); end
        checks++; if (lat != 17) begin errors++; $display("[TB] FAIL add_latency: got %0d expected 17", lat); end
        checks++; if (result !== 16'h0000) begin errors++; $display("[TB] FAIL add_result: got %h expected 0000", result); end
        checks++; if (flag !== 1'b1) begin errors++; $display("[TB] FAIL add_flag: got %b expected 1", flag); end
        checks++; if (result_id !== 5'd3) begin errors++; $display("[TB] FAIL add_id: got %0d expected 3", result_id); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_one_cycle: got %b expected 0", done); end
        checks++; if (result_id !== 5'd3) begin errors++; $display("[TB] FAIL id_held: got %0d expected 3", result_id); end

        run_req(3'd2, 16'd5, 16'd7, 5'd1, lat, seen, bz);
        checks++; if (result !== 16'hFFFE) begin errors++; $display("[TB] FAIL sub_5_7_result: got %h expected fffe", result); end
        checks++; if (flag !== 1'b1) begin errors++; $display("[TB] FAIL sub_5_7_flag: got %b expected 1", flag); end

        run_req(3'd2, 16'd7, 16'd5, 5'd2, lat, seen, bz);
        checks++; if (result !== 16'h0002) begin errors++; $display("[TB] FAIL sub_7_5_result: got %h expected 0002", result); end
        checks++; if (flag !== 1'b0) begin errors++; $display("[TB] FAIL sub_7_5_flag: got %b expected 0", flag); end

        run_req(3'd3, 16'h12FF, 16'h34FF, 5'd9, lat, seen, bz);
        checks++; if (lat != 9) begin errors++; $display("[TB] FAIL mul_latency: got %0d expected 9", lat); end
        checks++; if (result !== 16'hFE01) begin errors++; $display("[TB] FAIL mul_result: got %h expected fe01", result); end
        checks++; if (flag !== 1'b0) begin errors++; $display("[TB] FAIL mul_flag: got %b expected 0", flag); end

        run_req(3'd7, 16'hABCD, 16'h1234, 5'd21, lat, seen, bz);
        checks++; if (lat != 1) begin errors++; $display("[TB] FAIL illegal_latency: got %0d expected 1", lat); end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err: got %b expected 1", err); end
        checks++; if (result !== 16'h0000) begin errors++; $display("[TB] FAIL illegal_result: got %h expected 0000", result); end
        checks++; if (result_id !== 5'd21) begin errors++; $display("[TB] FAIL illegal_id: got %0d expected 21", result_id); end
    endtask

    task automatic test_back_to_back;
        int   lat, extra;
        logic seen, bz;
        logic [W-1:0] ra, rb;
        logic [W+1:0] exp;
        run_req(3'd6, 16'hF0F0, 16'hFFFF, 5'd4, lat, seen, bz);
        checks++; if (result !== 16'h0F0F) begin errors++; $display("[TB] FAIL b2b_xor_result: got %h expected 0f0f", result); end
        start = 1'b1; op = 3'd4; a = 16'hA5A5; b = 16'h3C3C; id = 5'd5;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_and_done: got %b expected 1", done); end
        checks++; if (result !== 16'h2424) begin errors++; $display("[TB] FAIL b2b_and_result: got %h expected 2424", result); end
        checks++; if (result_id !== 5'd5) begin errors++; $display("[TB] FAIL b2b_and_id: got %0d expected 5", result_id); end

        ra = W'($urandom); rb = W'($urandom);
        exp = model(3'd1, ra, rb);
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = ra; b = rb; id = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        seen = done;
        while (!seen && lat < BUDGET) begin
            if (lat == 4) begin
                start = 1'b1; op = 3'd3; a = W'($urandom); b = W'($urandom); id = 5'd10;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            seen = done;
        end
        start = 1'b0;
        checks++; if (lat != W + 1) begin errors++; $display("[TB] FAIL busy_start_latency: got %0d expected %0d", lat, W + 1); end
        checks++; if (result !== exp[W-1:0]) begin errors++; $display("[TB] FAIL busy_start_result: got %h expected %h", result, exp[W-1:0]); end
        checks++; if (result_id !== 5'd9) begin errors++; $display("[TB] FAIL busy_start_id: got %0d expected 9", result_id); end
        extra = 0;
        repeat (2 * W) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("[TB] FAIL busy_start_extra_done: got %0d expected 0", extra); end
    endtask

    task automatic test_reset_mid;
        int   lat, extra;
        logic seen, bz;
        logic [W-1:0] ra, rb;
        run_req(3'd6, 16'hF0F0, 16'h0FF0, 5'd6, lat, seen, bz);
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 16'h1234; b = 16'h4321; id = 5'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
        checks++; if (result !== '0) begin errors++; $display("[TB] FAIL abort_result: got %h expected 0", result); end
        checks++; if (result_id !== '0) begin errors++; $display("[TB] FAIL abort_id: got %h expected 0", result_id); end
        checks++; if (flag !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL abort_flags: got %b%b expected 00", flag, err); end
        ra = W'($urandom); rb = W'($urandom);
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = ra; b = rb; id = 5'd11;
        rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL first_after_reset_done: got %b expected 1", done); end
        checks++; if (result !== (ra ^ rb)) begin errors++; $display("[TB] FAIL first_after_reset_result: got %h expected %h", result, ra ^ rb); end
        checks++; if (result_id !== 5'd11) begin errors++; $display("[TB] FAIL first_after_reset_id: got %0d expected 11", result_id); end
        extra = 0;
        repeat (2 * W) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d expected 0", extra); end
    endtask

    task automatic test_random;
        int   lat;
        logic seen, bz, exp_busy;
        logic [2:0] r_op;
        logic [W-1:0] ra, rb;
        logic [ID_W-1:0] rid;
        logic [W+1:0] exp;
        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            ra = W'($urandom); rb = W'($urandom); rid = ID_W'($urandom);
            exp = model(r_op, ra, rb);
            exp_busy = (r_op == 3'd1) || (r_op == 3'd2) || (r_op == 3'd3);
            run_req(r_op, ra, rb, rid, lat, seen, bz);
            checks++; if (seen !== 1'b1 || lat != model_latency(r_op)) begin errors++; $display("[TB] FAIL rnd_latency op%0d: got %0d expected %0d", r_op, lat, model_latency(r_op)); end
            checks++; if (bz !== exp_busy) begin errors++; $display("[TB] FAIL rnd_busy op%0d: got %b expected %b", r_op, bz, exp_busy); end
            checks++; if (result !== exp[W-1:0]) begin errors++; $display("[TB] FAIL rnd_result op%0d a=%h b=%h: got %h expected %h", r_op, ra, rb, result, exp[W-1:0]); end
            checks++; if (flag !== exp[W]) begin errors++; $display("[TB] FAIL rnd_flag op%0d a=%h b=%h: got %b expected %b", r_op, ra, rb, flag, exp[W]); end
            checks++; if (err !== exp[W+1]) begin errors++; $display("[TB] FAIL rnd_err op%0d: got %b expected %b", r_op, err, exp[W+1]); end
            checks++; if (result_id !== rid) begin errors++; $display("[TB] FAIL rnd_id op%0d: got %0d expected %0d", r_op, result_id, rid); end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset;
        @(negedge clk);
        rst = 1'b1;
        test_directed;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pim_serial_alu.md
PIM_SERIAL_ALU -- requirements
Module: pim_serial_alu

Interface
REQ-001 Parameter W, default 16: operand/result width; even, 4..64.
REQ-002 Parameter ID_W, default 5: request tag width.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request strobe; sampled on clk rising edge.
REQ-006 op  input  3  opcode: NOP=0, ADD=1, SUB=2, MUL=3, AND=4, OR=5, XOR=6, 7 illegal.
REQ-007 a  input  W  first operand.
REQ-008 b  input  W  second operand.
REQ-009 id  input  ID_W  request tag.
REQ-010 busy  output  1  high while an accepted request is in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 result  output  W  operation result; valid when done, held until next done.
REQ-013 result_id  output  ID_W  tag of the completed request; valid when done.
REQ-014 flag  output  1  ADD carry-out, SUB borrow, else 0; valid with done.
REQ-015 err  output  1  high with done for opcode 7 or NOP.

Function
REQ-016 Request accepted on a rising edge where start=1 and busy=0; a, b, op and id are captured at that edge.
REQ-017 start while busy=1 ignored; no effect on captured operands.
REQ-018 FSM states IDLE, ADDSUB, MUL, FIN; IDLE->ADDSUB (op 1,2), IDLE->MUL (op 3), IDLE->FIN (ops 0,4-7), ADDSUB/MUL->FIN on last step, FIN->IDLE or FIN->next state if start accepted.
REQ-019 ADD/SUB bit-serial, LSB first, one bit per cycle, W cycles; SUB = a + ~b + 1 (carry in 1).
REQ-020 MUL: unsigned a[W/2-1:0] x b[W/2-1:0], shift-add one multiplier bit per cycle, W/2 cycles, full W-bit product, no overflow possible.
REQ-021 AND/OR/XOR: full-width bitwise, zero compute cycles.
REQ-022 NOP and opcode 7: result 0, flag 0, err 1.
REQ-023 done high exactly one cycle, in FIN; latency from accepting edge to done-high edge: W+1 (ADD/SUB), W/2+1 (MUL), 1 (logic/NOP/illegal).
REQ-024 busy high from accepting edge until FIN entered; busy=0 in FIN, so a start in the done cycle is accepted (back-to-back, no bubble).
REQ-025 result, result_id, flag, err update only on the edge entering FIN; held otherwise.
REQ-026 Operand inputs may change freely after acceptance without affecting the result.
REQ-027 ADD flag: carry out of bit W-1; SUB flag: 1 when a < b unsigned.

Reset
REQ-028 rst low: FSM to IDLE immediately; busy, done, flag, err 0; result, result_id 0; internal registers cleared.
REQ-029 Reset mid-operation aborts the request; no done is produced for it after release.
REQ-030 First request accepted on first rising edge after rst deasserts with start=1.

Structure
REQ-031 Package pim_alu_pkg holds opcode localparams/enum (NOP..XOR, ILLEGAL) and the FSM state type; shared with other PIM compute blocks.
REQ-032 One sub-module: pim_shift_add_mul (parameter N=W/2; start, operands, product, done), reused by future PIM tiles; bit-serial adder remains inline.

Verification (W=16, ID_W=5)
REQ-033 ADD a=0xFFFF b=0x0001 id=3 -> done 17 cycles after accept, result 0x0000, flag 1, result_id 3.
REQ-034 SUB a=5 b=7 -> result 0xFFFE, flag 1; SUB a=7 b=5 -> 0x0002, flag 0.
REQ-035 MUL a=0x12FF b=0x34FF -> done 9 cycles after accept, result 0xFE01, flag 0.
REQ-036 Back-to-back: XOR 0xF0F0^0xFFFF then start held in done cycle with AND -> done 1 cycle apart, results 0x0F0F, then AND value; start pulsed while ADD busy -> ignored, single done.
REQ-037 rst low at cycle 5 of an ADD -> outputs 0 immediately, no done after release; opcode 7 -> err 1, result 0, done after 1 cycle.
